// File: rtl/mmio_pkg.sv
// Shared types and constants for the mmio arbiter slice.
package mmio_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  // Read data returned when the register block never answers.
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, with wrap.
// The caller owns the pointer and decides when it advances.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_tmp;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;
  logic                 w_any;

  // Rotate so that the requester at ptr sits in bit 0.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];
  assign w_any = en & (|req);

  // Offset of the lowest set bit of the rotated vector.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path turns into a latch.
    w_off = '0;
    w_tmp = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      w_tmp = w_rot >> j;
      if (w_tmp[0]) w_off = IDX_W'(j);
    end
  end

  // Map the offset back to an absolute index and build the one-hot grant.
  always_comb begin
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W + 1)'(NUM_REQ)) w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
    grant_idx = w_sum[IDX_W-1:0];
    grant     = '0;
    if (w_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one mmio register block between NUM_REQ masters, one transaction
// at a time, round-robin. Reads wait for rd_valid_in or time out.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]             req_wr_in,
  input  logic [NUM_REQ-1:0]             req_rd_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [NUM_REQ-1:0]             rsp_valid_out,
  output logic [DATA_W-1:0]              rsp_data_out,
  output logic                           rsp_err_out,
  output logic [ADDR_W-1:0]              addr_out,
  output logic [DATA_W-1:0]              data_out,
  output logic                           wr_out,
  output logic                           rd_out,
  input  logic                           rd_valid_in,
  input  logic [DATA_W-1:0]              data_in
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic               r_is_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_err;

  logic [NUM_REQ-1:0] w_pending;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_arb_en;
  logic               w_accept;
  logic [IDX_W:0]     w_ptr_inc;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout;

  assign w_pending = req_wr_in | req_rd_in;
  assign w_arb_en  = (r_state == IDLE) & ~rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (w_pending),
    .ptr       (r_rr_ptr),
    .en        (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign req_ready_out = w_grant;
  assign w_accept      = |w_grant;

  // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
  assign w_ptr_inc  = {1'b0, w_grant_idx} + (IDX_W + 1)'(1);
  assign w_ptr_next = (w_ptr_inc == (IDX_W + 1)'(NUM_REQ)) ? '0 : w_ptr_inc[IDX_W-1:0];

  // Timeout fires on the WAIT cycle whose increment reaches the limit.
  assign w_cnt_inc = sat_inc(r_cnt);
  assign w_timeout = (w_cnt_inc >= TIMEOUT_LIM);

  assign addr_out     = r_addr;
  assign data_out     = r_data;
  assign rsp_data_out = r_rsp_data;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and strobe decode; everything is forced quiet while in reset.
  always_comb begin
    w_state_next  = r_state;
    wr_out        = 1'b0;
    rd_out        = 1'b0;
    rsp_valid_out = '0;
    rsp_err_out   = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_accept) w_state_next = ISSUE;
        end
        ISSUE: begin
          if (r_is_wr) begin
            wr_out       = 1'b1;
            w_state_next = IDLE;
          end else begin
            rd_out       = 1'b1;
            w_state_next = rd_valid_in ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (rd_valid_in || w_timeout) w_state_next = RESP;
        end
        RESP: begin
          rsp_valid_out[r_owner] = 1'b1;
          rsp_err_out            = r_rsp_err;
          w_state_next           = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Transaction capture, timeout counter and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant_idx;
        r_is_wr  <= req_wr_in[w_grant_idx];
        r_addr   <= req_addr_in[w_grant_idx];
        r_data   <= req_data_in[w_grant_idx];
        r_rr_ptr <= w_ptr_next;
      end
      case (r_state)
        ISSUE: begin
          r_cnt <= '0;
          if (!r_is_wr && rd_valid_in) begin
            r_rsp_data <= data_in;
            r_rsp_err  <= 1'b0;
          end
        end
        WAIT: begin
          if (rd_valid_in) begin
            r_rsp_data <= data_in;
            r_rsp_err  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_rsp_data <= TIMEOUT_DATA;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Random-stimulus bench for mmio_arbiter with a transaction-timeline model
// and a small memory standing in for the mmio register block.
module tb_mmio_arbiter;

  localparam int N      = 3;
  localparam int T      = 4;
  localparam int CYCLES = 4000;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0][31:0]  req_addr_in;
  logic [N-1:0][31:0]  req_data_in;
  logic [N-1:0]        req_wr_in;
  logic [N-1:0]        req_rd_in;
  logic [N-1:0]        req_ready_out;
  logic [N-1:0]        rsp_valid_out;
  logic [31:0]         rsp_data_out;
  logic                rsp_err_out;
  logic [31:0]         addr_out;
  logic [31:0]         data_out;
  logic                wr_out;
  logic                rd_out;
  logic                rd_valid_in;
  logic [31:0]         data_in;

  // Requester-side stimulus, one entry per master.
  bit          s_wr [N];
  bit          s_rd [N];
  logic [31:0] s_a  [N];
  logic [31:0] s_d  [N];

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign req_wr_in[g]   = s_wr[g];
    assign req_rd_in[g]   = s_rd[g];
    assign req_addr_in[g] = s_a[g];
    assign req_data_in[g] = s_d[g];
  end

  mmio_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_addr_in   (req_addr_in),
    .req_data_in   (req_data_in),
    .req_wr_in     (req_wr_in),
    .req_rd_in     (req_rd_in),
    .req_ready_out (req_ready_out),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_err_out   (rsp_err_out),
    .addr_out      (addr_out),
    .data_out      (data_out),
    .wr_out        (wr_out),
    .rd_out        (rd_out),
    .rd_valid_in   (rd_valid_in),
    .data_in       (data_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Model: one transaction at a time, described by its accept cycle t0.
  int          cyc;
  int          rr;
  bit          active;
  bit          t_wr;
  int          t_owner;
  int          t0;
  logic [31:0] t_addr;
  logic [31:0] t_data;
  int          resp_at;
  logic [31:0] resp_data;
  bit          resp_err;
  int          valid_at;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic [31:0] mem [logic [31:0]];

  function automatic int pick(input logic [N-1:0] pend, input int p);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      int j = (p + k) % N;
      sh = pend >> j;
      if (sh[0]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    rr       = 0;
    active   = 1'b0;
    resp_at  = -1;
    valid_at = -1;
    bus_addr = '0;
    bus_data = '0;
  endtask

  initial begin
    int          w;
    int          acc_idx;
    int          kind;
    bit          in_wait;
    bit          in_window;
    logic [N-1:0] pend;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_valid;

    rst         = 1'b1;
    rd_valid_in = 1'b0;
    data_in     = '0;
    for (int i = 0; i < N; i++) begin
      s_wr[i] = 1'b0;
      s_rd[i] = 1'b0;
      s_a[i]  = '0;
      s_d[i]  = '0;
    end
    acc_idx = -1;
    cyc     = 0;
    model_reset();

    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);

      // Reset: held at start, likely while a read is waiting, rare elsewhere.
      in_wait = active && !t_wr && (cyc >= t0 + 2) && (resp_at < 0);
      if (c < 2)        rst = 1'b1;
      else if (in_wait) rst = ($urandom_range(0, 7) == 0);
      else              rst = ($urandom_range(0, 499) == 0);

      // Requesters: release the one accepted last edge, then drop or start.
      if (acc_idx >= 0) begin
        s_wr[acc_idx] = 1'b0;
        s_rd[acc_idx] = 1'b0;
        acc_idx = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (s_wr[i] || s_rd[i]) begin
          if ($urandom_range(0, 15) == 0) begin
            s_wr[i] = 1'b0;
            s_rd[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          kind    = $urandom_range(0, 3);
          s_wr[i] = (kind != 2);
          s_rd[i] = (kind >= 2);
          s_a[i]  = 32'($urandom_range(0, 7)) << 2;
          s_d[i]  = $urandom;
        end
      end

      // mmio responder: planned answer inside the window, noise outside it.
      in_window = active && !t_wr && (cyc >= t0 + 1) && (resp_at < 0);
      if (in_window) begin
        rd_valid_in = (cyc == valid_at);
        if (cyc == valid_at) data_in = mem.exists(t_addr) ? mem[t_addr] : ~t_addr;
        else                 data_in = $urandom;
      end else begin
        rd_valid_in = ($urandom_range(0, 5) == 0);
        data_in     = $urandom;
      end

      pend = '0;
      for (int i = 0; i < N; i++) pend = pend | (N'(s_wr[i] | s_rd[i]) << i);
      w = (rst || active) ? -1 : pick(pend, rr);

      #1;
      exp_ready = (w >= 0) ? (N'(1) << w) : '0;
      check("ready", 32'(req_ready_out), 32'(exp_ready));
      if (!rst) begin
        check("wr_out", 32'(wr_out), 32'(active && t_wr && cyc == t0 + 1));
        check("rd_out", 32'(rd_out), 32'(active && !t_wr && cyc == t0 + 1));
        check("addr_out", addr_out, bus_addr);
        check("data_out", data_out, bus_data);
        exp_valid = (active && !t_wr && cyc == resp_at) ? (N'(1) << t_owner) : '0;
        check("rsp_valid", 32'(rsp_valid_out), 32'(exp_valid));
        if (exp_valid != '0) begin
          check("rsp_data", rsp_data_out, resp_data);
          check("rsp_err", 32'(rsp_err_out), 32'(resp_err));
        end
      end

      // Advance the model across the coming edge.
      if (rst) begin
        model_reset();
      end else if (!active) begin
        if (w >= 0) begin
          active   = 1'b1;
          t0       = cyc;
          t_owner  = w;
          t_wr     = s_wr[w];
          t_addr   = s_a[w];
          t_data   = s_d[w];
          rr       = (w + 1) % N;
          bus_addr = t_addr;
          bus_data = t_data;
          resp_at  = -1;
          valid_at = ($urandom_range(0, 4) == 0) ? -1 : cyc + 1 + $urandom_range(0, T + 1);
          acc_idx  = w;
        end
      end else if (t_wr) begin
        if (cyc == t0 + 1) begin
          mem[t_addr] = t_data;
          active = 1'b0;
        end
      end else if (resp_at < 0) begin
        if (cyc >= t0 + 1) begin
          if (rd_valid_in) begin
            resp_at   = cyc + 1;
            resp_data = data_in;
            resp_err  = 1'b0;
          end else if (cyc == t0 + T + 1) begin
            resp_at   = cyc + 1;
            resp_data = 32'hDEAD_BEEF;
            resp_err  = 1'b1;
          end
        end
      end else if (cyc == resp_at) begin
        active = 1'b0;
      end
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
